// File: rtl/div_fu.sv
// Fixed-latency RV32M divide unit (DIV/DIVU/REM/REMU) built on an iterative
// radix-4 restoring core; the result is published exactly LATENCY edges after issue.
module div_fu #(
   parameter int unsigned LATENCY = 24
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        EN,
   input  logic [1:0]  op,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   output logic [31:0] res,
   output logic        finish,
   output logic        busy
);

   localparam int unsigned XLEN       = 32;
   localparam int unsigned CALC_STEPS = 16;
   localparam int unsigned CNT_W      = $clog2(LATENCY + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIX,
      S_WAIT
   } state_t;

   state_t state, state_nxt;

   logic [CNT_W-1:0] cnt;
   logic [XLEN-1:0]  rem_r;
   logic [XLEN-1:0]  quot_r;
   logic [XLEN-1:0]  b_mag;
   logic [XLEN-1:0]  dividend;
   logic [XLEN-1:0]  final_r;
   logic             op_rem;
   logic             neg_q;
   logic             neg_r;
   logic             div0;
   logic             ovf;

   logic             signed_op_c;
   logic             a_neg_c;
   logic             b_neg_c;
   logic [XLEN-1:0]  a_mag_c;
   logic [XLEN-1:0]  b_mag_c;
   logic [2*XLEN-1:0] rq_nxt_c;
   logic [XLEN-1:0]  q_signed_c;
   logic [XLEN-1:0]  r_signed_c;
   logic [XLEN-1:0]  final_c;
   logic             last_calc_c;
   logic             publish_c;

   // One restoring step on {rem, quot}: shift left, trial-subtract the divisor.
   // The shifted remainder is 33 bits wide, so its carry-out forces a subtract.
   function automatic logic [2*XLEN-1:0] rstep(input logic [2*XLEN-1:0] rq,
                                               input logic [XLEN-1:0]   d);
      logic [XLEN:0] sh;
      logic          ge;
      sh = rq[2*XLEN-1:XLEN-1];
      ge = sh[XLEN] | (sh[XLEN-1:0] >= d);
      rstep = {(ge ? (sh[XLEN-1:0] - d) : sh[XLEN-1:0]), rq[XLEN-2:0], ge};
   endfunction

   // Operand conditioning at issue: magnitudes and sign handling.
   always_comb begin
      signed_op_c = ~op[0];
      a_neg_c     = signed_op_c & rs1_data[XLEN-1];
      b_neg_c     = signed_op_c & rs2_data[XLEN-1];
      a_mag_c     = a_neg_c ? (~rs1_data + XLEN'(1)) : rs1_data;
      b_mag_c     = b_neg_c ? (~rs2_data + XLEN'(1)) : rs2_data;
   end

   // Two radix-2 steps per cycle give one radix-4 quotient digit.
   always_comb begin
      rq_nxt_c = rstep(rstep({rem_r, quot_r}, b_mag), b_mag);
   end

   // Final value: sign fix-up, then special-case override.
   always_comb begin
      q_signed_c = neg_q ? (~quot_r + XLEN'(1)) : quot_r;
      r_signed_c = neg_r ? (~rem_r + XLEN'(1)) : rem_r;
      if (div0) begin
         final_c = op_rem ? dividend : {XLEN{1'b1}};
      end else if (ovf) begin
         final_c = op_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
      end else begin
         final_c = op_rem ? r_signed_c : q_signed_c;
      end
   end

   assign last_calc_c = (cnt == CNT_W'(CALC_STEPS - 1));
   assign publish_c   = (cnt == CNT_W'(LATENCY - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (EN) state_nxt = S_CALC;
         S_CALC: if (last_calc_c) state_nxt = S_FIX;
         S_FIX:  state_nxt = S_WAIT;
         S_WAIT: if (publish_c) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Datapath and registered outputs; cnt counts edges since the accepting edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         rem_r    <= '0;
         quot_r   <= '0;
         b_mag    <= '0;
         dividend <= '0;
         final_r  <= '0;
         op_rem   <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         div0     <= 1'b0;
         ovf      <= 1'b0;
         res      <= '0;
         finish   <= 1'b0;
         busy     <= 1'b0;
      end else begin
         finish <= 1'b0;
         case (state)
            S_IDLE: begin
               if (EN) begin
                  cnt      <= '0;
                  rem_r    <= '0;
                  quot_r   <= a_mag_c;
                  b_mag    <= b_mag_c;
                  dividend <= rs1_data;
                  op_rem   <= op[1];
                  neg_q    <= a_neg_c ^ b_neg_c;
                  neg_r    <= a_neg_c;
                  div0     <= (rs2_data == '0);
                  ovf      <= signed_op_c & (rs1_data == 32'h8000_0000)
                                          & (rs2_data == 32'hFFFF_FFFF);
                  busy     <= 1'b1;
               end
            end
            S_CALC: begin
               {rem_r, quot_r} <= rq_nxt_c;
               cnt             <= cnt + CNT_W'(1);
            end
            S_FIX: begin
               final_r <= final_c;
               cnt     <= cnt + CNT_W'(1);
            end
            S_WAIT: begin
               if (publish_c) begin
                  res    <= final_r;
                  finish <= 1'b1;
                  busy   <= 1'b0;
                  cnt    <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div_fu.sv
// Directed bench for div_fu: timing of the finish pulse, signed/unsigned
// results, special cases, ignored re-issue and reset abort.
module tb_div_fu;

   localparam int LAT = 24;

   logic        clk;
   logic        rst;
   logic        en;
   logic [1:0]  op;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic [31:0] res;
   logic        finish;
   logic        busy;

   int checks;
   int failures;

   typedef struct packed {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] e;
   } vec_t;

   localparam int NV = 14;
   vec_t vecs [NV];

   div_fu #(.LATENCY(LAT)) dut (
      .clk      (clk),
      .rst      (rst),
      .EN       (en),
      .op       (op),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data),
      .res      (res),
      .finish   (finish),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present an op so the next rising edge (T0) accepts it; returns at T0+1.
   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      en = 1'b1; op = o; rs1_data = a; rs2_data = b;
      @(posedge clk);
      #1;
      en = 1'b0;
   endtask

   // Observe n edges; report finish pulses, last pulse edge and res at that pulse.
   task automatic watch(input int n, output int pulses, output int edge_at, output logic [31:0] r_at);
      pulses = 0; edge_at = -1; r_at = 32'hDEAD_BEEF;
      for (int k = 1; k <= n; k++) begin
         @(posedge clk);
         #1;
         if (finish === 1'b1) begin
            pulses++; edge_at = k; r_at = res;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; en = 1'b0; op = 2'b00; rs1_data = '0; rs2_data = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (res !== 32'h0 || finish !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_state: res=%h finish=%b busy=%b, need res=0 finish=0 busy=0", res, finish, busy);
      end
      rst = 1'b0;
   endtask

   task automatic test_divu_basic;
      int p, e;
      logic [31:0] r;
      issue(2'b01, 32'd100, 32'd7);
      checks++;
      if (busy !== 1'b1) begin
         failures++; $display("FAIL busy_after_issue: busy=%b, need 1", busy);
      end
      watch(LAT + 3, p, e, r);
      checks++;
      if (p !== 1 || e !== LAT) begin
         failures++; $display("FAIL divu_timing: pulses=%0d edge=%0d, need pulses=1 edge=%0d", p, e, LAT);
      end
      checks++;
      if (r !== 32'd14) begin
         failures++; $display("FAIL divu_result: res=%h, need %h", r, 32'd14);
      end
      checks++;
      if (res !== 32'd14 || busy !== 1'b0 || finish !== 1'b0) begin
         failures++; $display("FAIL divu_hold: res=%h busy=%b finish=%b, need res=e busy=0 finish=0", res, busy, finish);
      end
   endtask

   task automatic test_vectors;
      int p, e;
      logic [31:0] r;
      vecs[0]  = '{2'b00, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD}; // DIV -7/2
      vecs[1]  = '{2'b10, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF}; // REM -7/2
      vecs[2]  = '{2'b11, 32'hFFFF_FFF9, 32'd2,          32'd1};         // REMU
      vecs[3]  = '{2'b00, 32'd5,         32'd0,          32'hFFFF_FFFF}; // DIV /0
      vecs[4]  = '{2'b11, 32'd5,         32'd0,          32'd5};         // REMU /0
      vecs[5]  = '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000}; // DIV ovf
      vecs[6]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0};         // REM ovf
      vecs[7]  = '{2'b00, 32'd7,         32'hFFFF_FFFE,  32'hFFFF_FFFD}; // DIV 7/-2
      vecs[8]  = '{2'b10, 32'd7,         32'hFFFF_FFFE,  32'd1};         // REM 7/-2
      vecs[9]  = '{2'b00, 32'h8000_0000, 32'd2,          32'hC000_0000}; // DIV -2^31/2
      vecs[10] = '{2'b10, 32'h8000_0000, 32'd3,          32'hFFFF_FFFE}; // REM -2^31/3
      vecs[11] = '{2'b01, 32'hFFFF_FFFF, 32'h0001_0000,  32'h0000_FFFF}; // DIVU
      vecs[12] = '{2'b11, 32'hFFFF_FFFF, 32'h0001_0000,  32'h0000_FFFF}; // REMU
      vecs[13] = '{2'b10, 32'hFFFF_FFF9, 32'd0,          32'hFFFF_FFF9}; // REM /0
      for (int i = 0; i < NV; i++) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b);
         watch(LAT + 1, p, e, r);
         checks++;
         if (p !== 1 || e !== LAT || r !== vecs[i].e) begin
            failures++;
            $display("FAIL vec%0d op=%b a=%h b=%h: res=%h pulses=%0d edge=%0d, need res=%h pulses=1 edge=%0d",
                     i, vecs[i].op, vecs[i].a, vecs[i].b, r, p, e, vecs[i].e, LAT);
         end
      end
   endtask

   task automatic test_back_to_back;
      int p, e;
      logic [31:0] r;
      issue(2'b01, 32'd100, 32'd7);
      p = 0; e = -1; r = 32'hDEAD_BEEF;
      for (int k = 1; k <= LAT; k++) begin
         if (k == 5) begin
            en = 1'b1; op = 2'b01; rs1_data = 32'd9; rs2_data = 32'd3;
         end
         @(posedge clk);
         #1;
         en = 1'b0;
         if (k == 6) begin
            checks++;
            if (busy !== 1'b1) begin
               failures++; $display("FAIL b2b_busy_mid: busy=%b, need 1", busy);
            end
         end
         if (finish === 1'b1) begin
            p++; e = k; r = res;
         end
      end
      checks++;
      if (p !== 1 || e !== LAT || r !== 32'd14) begin
         failures++;
         $display("FAIL b2b_ignored: res=%h pulses=%0d edge=%0d, need res=%h pulses=1 edge=%0d", r, p, e, 32'd14, LAT);
      end
      // Next edge is T0+25, the earliest legal accept.
      en = 1'b1; op = 2'b01; rs1_data = 32'd9; rs2_data = 32'd3;
      @(posedge clk);
      #1;
      en = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         failures++; $display("FAIL b2b_accept: busy=%b, need 1", busy);
      end
      watch(LAT + 1, p, e, r);
      checks++;
      if (p !== 1 || e !== LAT || r !== 32'd3) begin
         failures++;
         $display("FAIL b2b_second: res=%h pulses=%0d edge=%0d, need res=%h pulses=1 edge=%0d", r, p, e, 32'd3, LAT);
      end
   endtask

   task automatic test_reset_abort;
      int p, e;
      logic [31:0] r;
      issue(2'b01, 32'd1000, 32'd10);
      repeat (8) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checks++;
      if (res !== 32'h0 || busy !== 1'b0 || finish !== 1'b0) begin
         failures++;
         $display("FAIL abort_state: res=%h busy=%b finish=%b, need res=0 busy=0 finish=0", res, busy, finish);
      end
      watch(LAT + 6, p, e, r);
      checks++;
      if (p !== 0 || res !== 32'h0) begin
         failures++; $display("FAIL abort_no_finish: pulses=%0d res=%h, need pulses=0 res=0", p, res);
      end
      issue(2'b01, 32'd8, 32'd2);
      watch(LAT + 1, p, e, r);
      checks++;
      if (p !== 1 || e !== LAT || r !== 32'd4) begin
         failures++;
         $display("FAIL abort_recover: res=%h pulses=%0d edge=%0d, need res=%h pulses=1 edge=%0d", r, p, e, 32'd4, LAT);
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_divu_basic();
      test_vectors();
      test_back_to_back();
      test_reset_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
